// File: rtl/imm_ext_arbiter.sv
// rtl/imm_ext_arbiter.sv - two-requester round-robin immediate extender with registered output slot
//
// Purpose:
//   Two requesters (0 = decode, 1 = branch unit) compete for one output slot.
//   The granted instruction's immediate is decoded, extended to DW bits and
//   registered. The output slot behaves as a single-entry valid/ready stage.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   reset        - synchronous active-low reset
//   req_valid    - [1:0] per-requester request valid
//   req_ready    - [1:0] per-requester grant (combinational, one-hot or zero)
//   req_instr0/1 - requester instruction words
//   req_fmt0/1   - requester immediate formats (00 D, 01 I, 10 CB, 11 B)
//   out_valid    - registered result valid
//   out_ready    - consumer accepts the result
//   out_imm      - registered extended immediate
//   out_id       - requester index owning out_imm
module imm_ext_arbiter #(
    parameter int DW = 64,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [IW-1:0] req_instr0,
    input  logic [IW-1:0] req_instr1,
    input  logic [1:0]    req_fmt0,
    input  logic [1:0]    req_fmt1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_imm,
    output logic          out_id
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [DW-1:0] out_imm_q, out_imm_d;
    logic          out_id_q, out_id_d;

    logic          slot_free;
    logic          gnt_any;
    logic          gnt_idx;
    logic [IW-1:0] sel_instr;
    logic [1:0]    sel_fmt;
    logic [DW-1:0] ext_imm;

    // Only instruction bits [25:0] carry immediate fields.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{req_instr0[IW-1:26], req_instr1[IW-1:26]};

    // Arbitration looks only at req_valid, the pointer and slot status, so
    // req_ready never depends on instruction or format contents.
    always_comb begin
        slot_free = (state_q == ST_IDLE) || out_ready;
        gnt_any   = 1'b0;
        gnt_idx   = 1'b0;
        req_ready = 2'b00;
        if (reset && slot_free && (req_valid != 2'b00)) begin
            gnt_any = 1'b1;
            if (req_valid == 2'b11) begin
                gnt_idx = ptr_q;
            end else begin
                gnt_idx = req_valid[1];
            end
            req_ready = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_instr = gnt_idx ? req_instr1 : req_instr0;
        sel_fmt   = gnt_idx ? req_fmt1 : req_fmt0;
    end

    // Immediate field extraction and extension.
    always_comb begin
        ext_imm = '0;
        unique case (sel_fmt)
            2'b00:   ext_imm = {{(DW-9){sel_instr[20]}}, sel_instr[20:12]};
            2'b01:   ext_imm = {{(DW-12){1'b0}}, sel_instr[21:10]};
            2'b10:   ext_imm = {{(DW-19){sel_instr[23]}}, sel_instr[23:5]};
            default: ext_imm = {{(DW-26){sel_instr[25]}}, sel_instr[25:0]};
        endcase
    end

    // Next-state: a grant always reloads the slot; a drain without a new
    // grant empties it but leaves the last imm/id visible on the outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        out_imm_d = out_imm_q;
        out_id_d  = out_id_q;
        if (gnt_any) begin
            state_d   = ST_HOLD;
            out_imm_d = ext_imm;
            out_id_d  = gnt_idx;
            ptr_d     = ~gnt_idx;
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            out_imm_q <= '0;
            out_id_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            out_imm_q <= out_imm_d;
            out_id_q  <= out_id_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign out_imm   = out_imm_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// tb/tb_imm_ext_arbiter.sv - self-checking bench for imm_ext_arbiter
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_instr0, req_instr1;
    logic [1:0]  req_fmt0, req_fmt1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic        out_id;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the output slot and priority pointer.
    logic        m_valid;
    logic [63:0] m_imm;
    logic        m_id;
    logic        m_ptr;

    always #5 clk = ~clk;

    imm_ext_arbiter #(.DW(64), .IW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_instr0(req_instr0),
        .req_instr1(req_instr1),
        .req_fmt0  (req_fmt0),
        .req_fmt1  (req_fmt1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_id    (out_id)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Field position/width table applied arithmetically.
    function automatic logic [63:0] model_ext(input logic [31:0] ins, input logic [1:0] f);
        int lo, w;
        bit sgn;
        logic [63:0] mask, val;
        case (f)
            2'b00:   begin lo = 12; w = 9;  sgn = 1'b1; end
            2'b01:   begin lo = 10; w = 12; sgn = 1'b0; end
            2'b10:   begin lo = 5;  w = 19; sgn = 1'b1; end
            default: begin lo = 0;  w = 26; sgn = 1'b1; end
        endcase
        mask = (64'd1 << w) - 64'd1;
        val  = ({32'd0, ins} >> lo) & mask;
        if (sgn && val[w-1]) val = val | ~mask;
        return val;
    endfunction

    // One clock cycle: drive at negedge, check grant, then check the registered outputs.
    task automatic step(input logic [1:0] rv, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] f0, input logic [1:0] f1, input logic ordy,
                        input logic rst, input string tag);
        logic        g_any, g;
        logic [1:0]  exp_rdy;
        @(negedge clk);
        req_valid  = rv;
        req_instr0 = i0;
        req_instr1 = i1;
        req_fmt0   = f0;
        req_fmt1   = f1;
        out_ready  = ordy;
        reset      = rst;
        #1;
        g_any = rst && (!m_valid || ordy) && (rv != 2'b00);
        g     = (rv == 2'b11) ? m_ptr : rv[1];
        exp_rdy = !g_any ? 2'b00 : (g ? 2'b10 : 2'b01);
        check({tag, ".req_ready"}, {62'd0, req_ready}, {62'd0, exp_rdy});
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0; m_imm = '0; m_id = 1'b0; m_ptr = 1'b0;
        end else if (g_any) begin
            m_valid = 1'b1;
            m_imm   = g ? model_ext(i1, f1) : model_ext(i0, f0);
            m_id    = g;
            m_ptr   = ~g;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
        check({tag, ".out_imm"}, out_imm, m_imm);
        check({tag, ".out_id"}, {63'd0, out_id}, {63'd0, m_id});
    endtask

    logic [31:0] a, b;
    logic [63:0] held;

    initial begin
        m_valid = 1'b0; m_imm = '0; m_id = 1'b0; m_ptr = 1'b0;
        reset = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
        req_instr0 = '0; req_instr1 = '0; req_fmt0 = '0; req_fmt1 = '0;

        // Reset state; also pushes a request that must not be granted.
        step(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b1, 1'b0, "rst0");
        step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, "rst1");
        check("rst.out_imm_const", out_imm, 64'd0);

        // D-type sign extension.
        a = $urandom; a[20:12] = 9'b111000111;
        step(2'b01, a, 32'h0, 2'b00, 2'b00, 1'b1, 1'b1, "dtype");
        check("dtype.const", out_imm, 64'hFFFF_FFFF_FFFF_FFC7);
        check("dtype.id", {63'd0, out_id}, 64'd0);

        // I-type zero extension and B-type sign extension from requester 1.
        b = $urandom; b[21:10] = 12'hFFF; b[31] = 1'b1;
        step(2'b10, 32'h0, b, 2'b00, 2'b01, 1'b1, 1'b1, "itype");
        check("itype.const", out_imm, 64'h0000_0000_0000_0FFF);
        b = $urandom; b[25:0] = 26'h200_0000;
        step(2'b10, 32'h0, b, 2'b00, 2'b11, 1'b1, 1'b1, "btype");
        check("btype.const", out_imm, 64'hFFFF_FFFF_FE00_0000);

        // CB-type boundaries.
        a = $urandom; a[23:5] = 19'h40000;
        step(2'b01, a, 32'h0, 2'b10, 2'b00, 1'b1, 1'b1, "cbneg");
        check("cbneg.const", out_imm, 64'hFFFF_FFFF_FFFC_0000);
        a = $urandom; a[23:5] = 19'h3FFFF;
        step(2'b01, a, 32'h0, 2'b10, 2'b00, 1'b1, 1'b1, "cbpos");
        check("cbpos.const", out_imm, 64'h0000_0000_0003_FFFF);

        // Round-robin alternation after a fresh reset.
        step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b1, 1'b0, "rr_rst");
        for (int i = 0; i < 6; i++) begin
            step(2'b11, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b1, 1'b1, "rr");
            check("rr.id_seq", {63'd0, out_id}, {63'd0, 1'(i % 2)});
        end

        // Backpressure: slot held for 3 cycles, then a same-cycle grant on release.
        step(2'b01, $urandom, $urandom, 2'b11, 2'b11, 1'b1, 1'b1, "bp_load");
        held = out_imm;
        for (int i = 0; i < 3; i++) begin
            step(2'b11, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b0, 1'b1, "bp_hold");
            check("bp.stable", out_imm, held);
            check("bp.valid", {63'd0, out_valid}, 64'd1);
        end
        step(2'b11, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b1, 1'b1, "bp_rel");

        // Reset while holding discards the result; requester 0 wins first.
        step(2'b11, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b0, 1'b0, "hold_rst");
        check("hold_rst.valid", {63'd0, out_valid}, 64'd0);
        check("hold_rst.imm", out_imm, 64'd0);
        step(2'b11, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b1, 1'b1, "post_rst");
        check("post_rst.id", {63'd0, out_id}, 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom), $urandom, $urandom, 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 64, meaning the extended immediate width.
REQ-002 The block SHALL have parameter IW, default 32, meaning the instruction width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 The block SHALL have port req_valid, input, 2 bits: request valid, with bit 0 from decode and bit 1 from the branch unit.
REQ-006 The block SHALL have port req_ready, output, 2 bits: per-requester grant/accept, combinational.
REQ-007 The block SHALL have port req_instr0, input, IW bits: requester 0 instruction word.
REQ-008 The block SHALL have port req_instr1, input, IW bits: requester 1 instruction word.
REQ-009 The block SHALL have port req_fmt0, input, 2 bits: requester 0 immediate format.
REQ-010 The block SHALL have port req_fmt1, input, 2 bits: requester 1 immediate format.
REQ-011 The block SHALL have port out_valid, output, 1 bit: registered result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port out_imm, output, DW bits: registered extended immediate.
REQ-014 The block SHALL have port out_id, output, 1 bit: index of the requester that owns out_imm.

Function
REQ-015 Format decode SHALL be:
- fmt 00: D-type, instr[20:12] sign-extended to DW.
- fmt 01: I-type, instr[21:10] zero-extended to DW.
- fmt 10: CB-type, instr[23:5] sign-extended to DW.
- fmt 11: B-type, instr[25:0] sign-extended to DW.
REQ-016 Sign extension SHALL replicate the field MSB into every bit above the field.
REQ-017 The block SHALL be a two-state FSM:
- IDLE: out_valid=0.
- HOLD: out_valid=1.
REQ-018 The output slot is free when the state is IDLE, or when the state is HOLD and out_ready=1 in the same cycle.
REQ-019 When the slot is free and any req_valid bit is 1, exactly one requester SHALL be granted; req_ready is 1 only for that requester.
REQ-020 The result of a grant SHALL be loaded into out_imm/out_id on the next clk edge; state becomes HOLD, giving 1-cycle latency.
REQ-021 If the state is HOLD, out_ready=1 and no request is granted, the state SHALL return to IDLE with out_imm/out_id unchanged.
REQ-022 If the state is HOLD and out_ready=0, req_ready SHALL be 2'b00 and out_imm/out_id/out_valid SHALL hold their values.
REQ-023 Arbitration SHALL be round-robin with a 1-bit priority pointer:
- When both requesters are valid, the pointed requester wins.
- When one requester is valid, it wins.
- After every grant, the pointer SHALL be set to the non-granted index.
REQ-024 Back-to-back grants on consecutive cycles SHALL be supported when out_ready stays 1; throughput is 1 result per cycle.
REQ-025 req_ready SHALL never depend on req_fmt or req_instr.
REQ-026 A requester whose req_valid falls without a grant SHALL lose nothing; the pointer is unchanged by non-grant cycles.

Reset
REQ-027 When reset=0 at a clk edge, the block SHALL set state=IDLE, out_valid=0, out_imm=0, out_id=0 and pointer=0.
REQ-028 While reset=0, req_ready SHALL be 2'b00.
REQ-029 Reset asserted in HOLD SHALL discard the held result with no handshake completion.
REQ-030 The first grant after reset SHALL go to requester 0 if both requesters are valid.

Verification
REQ-031 Requester 0 sends fmt 00 with instr[20:12]=9'b111000111 and out_ready=1 -> the next cycle has out_valid=1, out_imm=64'hFFFFFFFFFFFFFFC7, out_id=0.
REQ-032 Requester 1 sends fmt 01 with instr[21:10]=12'hFFF -> out_imm=64'h0000000000000FFF; fmt 11 with instr[25:0]=26'h2000000 -> out_imm=64'hFFFFFFFFFE000000.
REQ-033 Both req_valid are held at 1 for 6 cycles with out_ready=1 -> the out_id sequence is 0,1,0,1,0,1 and req_ready is one-hot every cycle.
REQ-034 A result is in HOLD and out_ready=0 for 3 cycles with both requests valid -> req_ready=00 and out_imm is stable for those 3 cycles; out_ready then rises -> grant occurs in that same cycle and the new result appears the next cycle.
REQ-035 Reset=0 is applied in HOLD with out_ready=0 -> out_valid=0 and out_imm=0 the next cycle; after release, with both requesters valid, requester 0 is granted first.
REQ-036 CB-type with instr[23:5]=19'h40000 -> out_imm=64'hFFFFFFFFFFFC0000; with 19'h3FFFF -> out_imm=64'h000000000003FFFF.
